// File: rtl/clock_divider_bank.sv
// rtl/clock_divider_bank.sv - bank of run-time programmable clock dividers with shadowed divisors
module clock_divider_bank #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 16,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NUM_CH-1:0] en_i,
    input  logic              sync_i,
    input  logic              cfg_we_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [DIV_W-1:0]  cfg_div_i,
    output logic [NUM_CH-1:0] gen_clk_o,
    output logic [NUM_CH-1:0] rise_stb_o,
    output logic [NUM_CH-1:0] fall_stb_o,
    output logic [NUM_CH-1:0] busy_o,
    output logic [NUM_CH-1:0] cfg_pend_o
);

    typedef enum logic {IDLE, RUN} state_t;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        state_t           state;
        logic [DIV_W-1:0] cnt;
        logic [DIV_W-1:0] div_q;
        logic [DIV_W-1:0] div_p;
        logic [DIV_W-1:0] half;
        logic [DIV_W-1:0] next_div;
        logic             pend;
        logic             wr;
        logic             last;
        logic             gen_q;
        logic             rise_q;
        logic             fall_q;

        // Out-of-range channel indices match no channel, so such writes are dropped.
        assign wr       = cfg_we_i && (cfg_ch_i == CH_W'(g));
        assign half     = div_q - (div_q >> 1);
        assign last     = (cnt >= div_q - DIV_W'(1));
        assign next_div = pend ? div_p : div_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state  <= IDLE;
                cnt    <= '0;
                div_q  <= '0;
                div_p  <= '0;
                pend   <= 1'b0;
                gen_q  <= 1'b0;
                rise_q <= 1'b0;
                fall_q <= 1'b0;
            end else begin
                gen_q  <= (state == RUN) && (cnt < half);
                rise_q <= (state == RUN) && (cnt == '0);
                fall_q <= (state == RUN) && (cnt == half);

                case (state)
                    IDLE: begin
                        cnt <= '0;
                        if (pend) begin
                            div_q <= div_p;
                            pend  <= 1'b0;
                        end
                        if (en_i[g] && (div_q >= DIV_W'(2)))
                            state <= RUN;
                    end
                    RUN: begin
                        // sync restarts the period early and keeps the channel running
                        if (sync_i || last) begin
                            cnt <= '0;
                            if (pend) begin
                                div_q <= div_p;
                                pend  <= 1'b0;
                            end
                            if ((next_div < DIV_W'(2)) || (!sync_i && !en_i[g]))
                                state <= IDLE;
                        end else begin
                            cnt <= cnt + DIV_W'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase

                // A write in the same cycle as an application leaves the new value pending.
                if (wr) begin
                    div_p <= cfg_div_i;
                    pend  <= 1'b1;
                end
            end
        end

        assign gen_clk_o[g]  = gen_q;
        assign rise_stb_o[g] = rise_q;
        assign fall_stb_o[g] = fall_q;
        assign busy_o[g]     = (state == RUN);
        assign cfg_pend_o[g] = pend;
    end

endmodule
